uart_io_unit: RTL and testbench
===============================

# uart_io_unit

Byte-wide UART endpoint between the CPU core's I/O instructions and the board serial pins. The core issues one request at a time (send a byte, or wait for a received byte) with a single-cycle go pulse, then stalls until a single-cycle done pulse. Framing is fixed 8N1 at a parameterised bit period.

## Interface
- CLKS_PER_BIT, default 868: clock cycles per serial bit (100 MHz / 115200). Legal range is ≥ 4.
- clk  in  1  system clock; all logic on the rising edge.
- rstn  in  1  reset. One clock domain; reset is asynchronous and active-high (1 = reset), despite the port name.
- uart_done  out  1  one-cycle completion pulse for the current request.
- rors  in  1  request type, sampled with uart_go: 1 = receive, 0 = send.
- uart_go  in  1  one-cycle request strobe.
- rxdata  out  8  last successfully received byte. Holds until the next successful reception.
- txdata  in  8  byte to send, sampled with uart_go when rors = 0.
- txd  out  1  serial output; idle high.
- rxd  in  1  serial input; asynchronous to clk.

## Operation
- Reset values: txd = 1, uart_done = 0, rxdata = 8'h00, FSM = IDLE, rxd synchroniser flops = 1.
- Control FSM states are IDLE, SEND and RECV.
  - IDLE + uart_go + rors = 0: latch txdata, go to SEND.
  - IDLE + uart_go + rors = 1: go to RECV.
  - uart_go in SEND or RECV is ignored. No queueing, no abort.
- SEND:
  - Frame order: start bit (0), data bits 0..7 (LSB first), stop bit (1).
  - Each bit lasts exactly CLKS_PER_BIT cycles.
  - When the stop bit ends: pulse uart_done and return to IDLE.
- Receiver:
  - rxd passes through a 2-flop synchroniser.
  - Start is detected on a synchronised 1→0 edge.
  - Start is re-checked at mid-bit (CLKS_PER_BIT/2 cycles later). If high, it is a glitch: resume hunting.
  - Data bits and the stop bit are then sampled every CLKS_PER_BIT cycles at mid-bit.
  - If the stop bit is 1: the byte is valid.
  - If the stop bit is 0 (framing error): discard the byte, leave rxdata unchanged, and wait for synchronised rxd = 1 before hunting again.
- RECV: on a valid byte, load rxdata, pulse uart_done in the same cycle rxdata updates, and return to IDLE.
- Reset mid-operation: an active frame is dropped immediately and txd is forced to 1.

## Timing
- Let uart_go be sampled high at edge E0.
  - txd falls at E0.
  - txd returns to the stop level at E0 + 9·N.
  - uart_done is high for the cycle following edge E0 + 10·N, where N = CLKS_PER_BIT.
- The FSM is in IDLE in the uart_done cycle. A uart_go in that same cycle is accepted.
- Receive completion latency: uart_done follows the stop-bit mid-sample by one edge, plus 2 cycles of synchroniser delay relative to the rxd pin.
- rxdata changes only on the edge that raises uart_done (receive).

## Configuration
- Macro UART_RX_BUF_EN.
- Defined:
  - The receiver runs continuously, including in IDLE and SEND.
  - A valid byte arriving outside RECV is stored in a one-byte buffer with a valid flag. A newer byte overwrites it.
  - A receive request with the buffer valid loads rxdata, clears the flag, and pulses uart_done one cycle after the uart_go edge.
- Undefined:
  - The receiver hunts only while in RECV.
  - Bytes arriving outside RECV are lost.
  - A frame already in progress when RECV is entered is not detected mid-frame.

## Structure
- Package uart_pkg holds:
  - the control state enum (IDLE/SEND/RECV);
  - the receiver state enum (HUNT/START/DATA/STOP/WAIT_IDLE);
  - constants DATA_BITS = 8 and FRAME_BITS = 10;
  - the default CLKS_PER_BIT.
- One sub-module, uart_rx, holds the synchroniser, receive FSM and bit counter. Outputs: byte, byte_valid pulse, active.
- The transmitter and control FSM stay in uart_io_unit.

## Test plan
All scenarios use CLKS_PER_BIT = 4.
- Reset: hold rstn = 1 for 7 cycles, release → txd = 1, uart_done = 0, rxdata = 00 throughout.
- Send: uart_go with rors = 0, txdata = F0 → txd carries 0,0,0,0,0,1,1,1,1,1, each bit held 4 cycles. uart_done is pulsed once, 40 cycles after go.
- Receive: uart_go with rors = 1, then drive the frame for 0xA5 on rxd → rxdata = A5 with a single uart_done pulse.
- Framing error: rors = 1 request, then hold rxd = 0 indefinitely → no uart_done, rxdata stays 00. A later valid 0x3C frame (after rxd returns high) completes with rxdata = 3C.
- Busy ignore: during an active receive, pulse uart_go with rors = 0 → txd stays 1 and the pending receive still completes normally.
- With UART_RX_BUF_EN: 0x55 arrives while IDLE, then a rors = 1 request → uart_done one cycle after go, rxdata = 55.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the UART I/O unit.
//   - ctrl_state_t : control FSM states of uart_io_unit (IDLE/SEND/RECV)
//   - rx_state_t   : receiver FSM states of uart_rx
//   - DATA_BITS, FRAME_BITS : 8N1 framing (start + 8 data + stop)
//   - CLKS_PER_BIT_DEF      : default bit period (100 MHz / 115200)
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int FRAME_BITS       = 10;
  localparam int CLKS_PER_BIT_DEF = 868;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    RECV
  } ctrl_state_t;

  typedef enum logic [2:0] {
    HUNT,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } rx_state_t;

endpackage

// File: rtl/uart_io_unit_if.sv
// Request/response bus between the CPU core I/O instructions and uart_io_unit.
//   uart_go   : one-cycle request strobe (core -> unit)
//   rors      : request type sampled with uart_go, 1 = receive, 0 = send
//   txdata    : byte to send, sampled with uart_go when rors = 0
//   uart_done : one-cycle completion pulse (unit -> core)
//   rxdata    : last successfully received byte
// master = core side, slave = uart_io_unit side.
interface uart_io_unit_if;

  logic       uart_go;
  logic       rors;
  logic [7:0] txdata;
  logic       uart_done;
  logic [7:0] rxdata;

  modport master (
    output uart_go,
    output rors,
    output txdata,
    input  uart_done,
    input  rxdata
  );

  modport slave (
    input  uart_go,
    input  rors,
    input  txdata,
    output uart_done,
    output rxdata
  );

endinterface

// File: rtl/uart_io_unit_rx.sv
// uart_rx: 8N1 serial receiver with a 2-flop input synchroniser.
// Ports:
//   clk, rst   : system clock, asynchronous active-high reset
//   enable     : allows start-bit hunting; dropping it abandons any frame
//   rxd        : serial input, asynchronous to clk
//   byte_data  : assembled byte, meaningful when byte_valid pulses
//   byte_valid : one-cycle pulse after a frame with a good stop bit
//   active     : receiver is inside a frame (not hunting)
//
// state     | meaning
// HUNT      | waiting for a synchronised 1->0 edge
// START     | counting to start-bit middle, re-checking it is still low
// DATA      | sampling 8 data bits at mid-bit, LSB first
// STOP      | sampling the stop bit at mid-bit
// WAIT_IDLE | framing error seen, waiting for the line to go high
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] byte_data,
  output logic                 byte_valid,
  output logic                 active
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  rx_state_t            state;
  logic                 rx_meta;
  logic                 rx_sync;
  logic                 rx_prev;
  logic [CW-1:0]        cnt;
  logic [2:0]           bit_idx;
  logic [DATA_BITS-1:0] shift;

  assign byte_data = shift;
  assign active    = (state != HUNT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= HUNT;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
    end else begin
      rx_meta    <= rxd;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      byte_valid <= 1'b0;
      if (!enable) begin
        state <= HUNT;
      end else begin
        case (state)
          HUNT: begin
            if (rx_prev && !rx_sync) begin
              cnt   <= CW'(CLKS_PER_BIT / 2 - 1);
              state <= START;
            end
          end
          START: begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
            end else if (rx_sync) begin
              state <= HUNT;  // glitch shorter than half a bit
            end else begin
              cnt     <= CW'(CLKS_PER_BIT - 1);
              bit_idx <= '0;
              state   <= DATA;
            end
          end
          DATA: begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
            end else begin
              shift <= {rx_sync, shift[DATA_BITS-1:1]};
              cnt   <= CW'(CLKS_PER_BIT - 1);
              if (bit_idx == 3'(DATA_BITS - 1)) begin
                state <= STOP;
              end else begin
                bit_idx <= bit_idx + 3'd1;
              end
            end
          end
          STOP: begin
            if (cnt != '0) begin
              cnt <= cnt - CW'(1);
            end else if (rx_sync) begin
              byte_valid <= 1'b1;
              state      <= HUNT;
            end else begin
              state <= WAIT_IDLE;
            end
          end
          WAIT_IDLE: begin
            if (rx_sync) state <= HUNT;
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_io_unit.sv
// uart_io_unit: byte-wide 8N1 UART endpoint for the CPU core I/O instructions.
// Ports:
//   clk  : system clock
//   rstn : asynchronous reset, active HIGH despite the name
//   bus  : uart_io_unit_if.slave (uart_go, rors, txdata, uart_done, rxdata)
//   txd  : serial output, idle high
//   rxd  : serial input, asynchronous to clk
// Build option UART_RX_BUF_EN: receiver runs continuously and keeps the
// latest byte that arrives outside a receive request in a one-byte buffer.
//
// state | meaning
// IDLE  | waiting for uart_go
// SEND  | shifting out start, 8 data bits, stop
// RECV  | waiting for a valid received byte
module uart_io_unit
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  uart_io_unit_if.slave bus,
  output logic          txd,
  input  logic          rxd
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  ctrl_state_t           state;
  logic [CW-1:0]         tx_cnt;
  logic [3:0]            tx_bit;
  logic [FRAME_BITS-1:0] tx_frame;

  logic                  rx_enable;
  logic                  rx_valid;
  logic                  rx_active;
  logic [DATA_BITS-1:0]  rx_byte;

`ifdef UART_RX_BUF_EN
  logic [DATA_BITS-1:0]  rx_buf_data;
  logic                  rx_buf_valid;

  assign rx_enable = 1'b1;
`else
  // Hunt only during a request, but let a frame already underway finish.
  assign rx_enable = (state == RECV) || rx_active;
`endif

  uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .rst        (rstn),
    .enable     (rx_enable),
    .rxd        (rxd),
    .byte_data  (rx_byte),
    .byte_valid (rx_valid),
    .active     (rx_active)
  );

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state         <= IDLE;
      tx_cnt        <= '0;
      tx_bit        <= '0;
      tx_frame      <= '1;
      txd           <= 1'b1;
      bus.uart_done <= 1'b0;
      bus.rxdata    <= '0;
`ifdef UART_RX_BUF_EN
      rx_buf_data   <= '0;
      rx_buf_valid  <= 1'b0;
`endif
    end else begin
      bus.uart_done <= 1'b0;
`ifdef UART_RX_BUF_EN
      if (rx_valid && state != RECV) begin
        rx_buf_data  <= rx_byte;
        rx_buf_valid <= 1'b1;
      end
`endif
      case (state)
        IDLE: begin
          if (bus.uart_go) begin
            if (bus.rors) begin
              state <= RECV;
            end else begin
              // Frame LSB is the start bit; txd leaves idle on this edge.
              tx_frame <= {1'b1, bus.txdata, 1'b0};
              txd      <= 1'b0;
              tx_cnt   <= CW'(CLKS_PER_BIT - 1);
              tx_bit   <= '0;
              state    <= SEND;
            end
          end
        end
        SEND: begin
          if (tx_cnt != '0) begin
            tx_cnt <= tx_cnt - CW'(1);
          end else if (tx_bit == 4'(FRAME_BITS - 1)) begin
            txd           <= 1'b1;
            bus.uart_done <= 1'b1;
            state         <= IDLE;
          end else begin
            tx_frame <= {1'b1, tx_frame[FRAME_BITS-1:1]};
            txd      <= tx_frame[1];
            tx_cnt   <= CW'(CLKS_PER_BIT - 1);
            tx_bit   <= tx_bit + 4'd1;
          end
        end
        RECV: begin
`ifdef UART_RX_BUF_EN
          // A fresh byte wins over an older buffered one.
          if (rx_valid) begin
            bus.rxdata    <= rx_byte;
            bus.uart_done <= 1'b1;
            rx_buf_valid  <= 1'b0;
            state         <= IDLE;
          end else if (rx_buf_valid) begin
            bus.rxdata    <= rx_buf_data;
            bus.uart_done <= 1'b1;
            rx_buf_valid  <= 1'b0;
            state         <= IDLE;
          end
`else
          if (rx_valid) begin
            bus.rxdata    <= rx_byte;
            bus.uart_done <= 1'b1;
            state         <= IDLE;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_io_unit.sv
// Self-checking bench for uart_io_unit at CLKS_PER_BIT = 4.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_io_unit;

  localparam int N       = 4;
  localparam int LAT_NOM = 9 * N + N / 2 + 3;  // frame start -> uart_done seen

  logic clk;
  logic rstn;
  logic txd;
  logic rxd;

  uart_io_unit_if bus ();

  uart_io_unit #(
    .CLKS_PER_BIT (N)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus),
    .txd  (txd),
    .rxd  (rxd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         n_chk  = 0;
  int         n_fail = 0;
  logic [7:0] model_rxdata;
  logic [7:0] tx_q [4];

  int         rx_dones;
  int         rx_done_at;
  logic [7:0] rx_done_data;
  logic       txd_went_low;
  logic       early_change;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Send tx_q[0..nbytes-1] back to back; each next go is issued in the done cycle.
  task automatic tx_chain(input int nbytes);
    logic [9:0] frame;
    int         early;
    @(negedge clk);
    bus.uart_go = 1'b1;
    bus.rors    = 1'b0;
    bus.txdata  = tx_q[0];
    for (int k = 0; k < nbytes; k++) begin
      frame = {1'b1, tx_q[k], 1'b0};
      early = 0;
      for (int i = 0; i <= 10 * N; i++) begin
        @(negedge clk);
        if (i == 0) bus.uart_go = 1'b0;
        if (i < 10 * N) begin
          chk("tx_bit", txd, frame[i / N]);
          if (bus.uart_done) early++;
        end else begin
          chk("tx_done_early", early, 0);
          chk("tx_done", bus.uart_done, 1);
          chk("tx_idle_level", txd, 1);
          if (k + 1 < nbytes) begin
            bus.uart_go = 1'b1;
            bus.txdata  = tx_q[k + 1];
          end
        end
      end
    end
    @(negedge clk);
    chk("tx_done_single", bus.uart_done, 0);
    chk("tx_idle_after", txd, 1);
  endtask

  task automatic rx_request();
    @(negedge clk);
    bus.uart_go = 1'b1;
    bus.rors    = 1'b1;
    @(negedge clk);
    bus.uart_go = 1'b0;
  endtask

  // Drive one serial frame plus a tail; optionally pulse a send request at go_at.
  task automatic drive_rx(input logic [7:0] b, input logic stop_v, input int tail,
                          input logic tail_lvl, input int go_at, input logic [7:0] go_tx);
    logic [9:0] frame;
    logic [7:0] start_data;
    frame        = {stop_v, b, 1'b0};
    start_data   = bus.rxdata;
    rx_dones     = 0;
    rx_done_at   = -1;
    rx_done_data = 8'h00;
    txd_went_low = 1'b0;
    early_change = 1'b0;
    for (int i = 0; i < 10 * N + tail; i++) begin
      if (bus.uart_done) begin
        rx_dones++;
        if (rx_done_at < 0) begin
          rx_done_at   = i;
          rx_done_data = bus.rxdata;
        end
      end else if (rx_dones == 0 && bus.rxdata !== start_data) begin
        early_change = 1'b1;
      end
      if (txd !== 1'b1) txd_went_low = 1'b1;
      rxd = (i < 10 * N) ? frame[i / N] : tail_lvl;
      if (i == go_at) begin
        bus.uart_go = 1'b1;
        bus.rors    = 1'b0;
        bus.txdata  = go_tx;
      end else begin
        bus.uart_go = 1'b0;
      end
      @(negedge clk);
    end
  endtask

  task automatic rx_expect_ok(input logic [7:0] b);
    chk("rx_dones", rx_dones, 1);
    chk("rx_data_at_done", rx_done_data, b);
    chk("rx_latency", (rx_done_at >= LAT_NOM - 2) && (rx_done_at <= LAT_NOM + 2), 1);
    chk("rx_early_change", early_change, 0);
    chk("rx_hold", bus.rxdata, b);
    model_rxdata = b;
  endtask

  initial begin
    logic [7:0] b;
    int         cnt;

    rstn         = 1'b1;
    rxd          = 1'b1;
    bus.uart_go  = 1'b0;
    bus.rors     = 1'b0;
    bus.txdata   = 8'h00;
    model_rxdata = 8'h00;

    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("rst_txd", txd, 1);
      chk("rst_done", bus.uart_done, 0);
      chk("rst_rxdata", bus.rxdata, 0);
    end
    rstn = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_rst_txd", txd, 1);
      chk("post_rst_done", bus.uart_done, 0);
      chk("post_rst_rxdata", bus.rxdata, 0);
    end

    // Send: F0 then random bytes, chained through the done cycle.
    tx_q[0] = 8'hF0;
    for (int k = 1; k < 4; k++) tx_q[k] = 8'($urandom_range(255));
    tx_chain(4);

    // Framing error with the line held low, then recovery with 0x3C.
    rx_request();
    drive_rx(8'($urandom_range(255)), 1'b0, 30, 1'b0, -1, 8'h00);
    chk("ferr_dones", rx_dones, 0);
    chk("ferr_rxdata", bus.rxdata, model_rxdata);
    rxd = 1'b1;
    repeat (2 * N) @(negedge clk);
    drive_rx(8'h3C, 1'b1, 12, 1'b1, -1, 8'h00);
    rx_expect_ok(8'h3C);

    // Plain receive of 0xA5.
    rx_request();
    drive_rx(8'hA5, 1'b1, 12, 1'b1, -1, 8'h00);
    rx_expect_ok(8'hA5);

    // Start glitch shorter than half a bit is rejected.
    rx_request();
    cnt = 0;
    for (int i = 0; i < 3 * N; i++) begin
      if (bus.uart_done) cnt++;
      rxd = (i == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
    end
    chk("glitch_no_done", cnt, 0);
    b = 8'($urandom_range(255));
    drive_rx(b, 1'b1, 12, 1'b1, -1, 8'h00);
    rx_expect_ok(b);

    // Random receives; the second one gets a send request while busy.
    for (int r = 0; r < 3; r++) begin
      b = 8'($urandom_range(255));
      rx_request();
      drive_rx(b, 1'b1, 12, 1'b1, (r == 1) ? 15 : -1, 8'($urandom_range(255)));
      rx_expect_ok(b);
      chk("busy_txd_idle", txd_went_low, 0);
    end

`ifdef UART_RX_BUF_EN
    // Byte arriving while idle is buffered and returned on the next request.
    drive_rx(8'h55, 1'b1, 12, 1'b1, -1, 8'h00);
    chk("buf_idle_no_done", rx_dones, 0);
    @(negedge clk);
    bus.uart_go = 1'b1;
    bus.rors    = 1'b1;
    @(negedge clk);
    bus.uart_go = 1'b0;
    chk("buf_done_not_yet", bus.uart_done, 0);
    @(negedge clk);
    chk("buf_done", bus.uart_done, 1);
    chk("buf_rxdata", bus.rxdata, 8'h55);
    model_rxdata = 8'h55;
    @(negedge clk);
    chk("buf_done_single", bus.uart_done, 0);
`else
    // Byte arriving while idle is lost; a later request still works.
    drive_rx(8'($urandom_range(255)), 1'b1, 12, 1'b1, -1, 8'h00);
    chk("idle_lost_dones", rx_dones, 0);
    chk("idle_lost_rxdata", bus.rxdata, model_rxdata);
    b = 8'($urandom_range(255));
    rx_request();
    drive_rx(b, 1'b1, 12, 1'b1, -1, 8'h00);
    rx_expect_ok(b);
`endif

    // Reset in the middle of a send forces txd high at once.
    @(negedge clk);
    bus.uart_go = 1'b1;
    bus.rors    = 1'b0;
    bus.txdata  = 8'h00;
    @(negedge clk);
    bus.uart_go = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_rst_txd_low", txd, 0);
    rstn = 1'b1;
    #1;
    chk("async_rst_txd", txd, 1);
    chk("async_rst_rxdata", bus.rxdata, 0);
    model_rxdata = 8'h00;
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12 * N; i++) begin
      @(negedge clk);
      if (bus.uart_done || txd !== 1'b1) cnt++;
    end
    chk("rst_frame_dropped", cnt, 0);
    chk("rst_rxdata_model", bus.rxdata, model_rxdata);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
